// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request, honoured only while idle
//   dividend   numerator, captured on the accepting edge
//   divisor    denominator, captured on the accepting edge
//   busy       high while an operation is running or completing
//   done       one-cycle completion pulse; results valid from this cycle on
//   quotient   registered quotient (all ones on divide by zero)
//   remainder  registered remainder (dividend on divide by zero)
//   divByZero  registered flag, set when the last operation had divisor == 0

module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part;     // partial remainder, always < divisor between steps
    logic [WIDTH-1:0] shift;    // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] hold;     // captured divisor

    logic [WIDTH:0]   part_shift;
    logic [WIDTH-1:0] diff;
    logic             q_bit;
    logic [WIDTH-1:0] part_step;
    logic [WIDTH-1:0] shift_step;

    // One restoring step. The shifted partial remainder needs WIDTH+1 bits for
    // the compare, but when the subtraction is taken the result is below the
    // divisor, so a WIDTH-bit difference is exact.
    always_comb begin
        part_shift = {part, shift[WIDTH-1]};
        q_bit      = (part_shift >= {1'b0, hold});
        diff       = part_shift[WIDTH-1:0] - hold;
        part_step  = q_bit ? diff : part_shift[WIDTH-1:0];
        shift_step = {shift[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            part      <= '0;
            shift     <= '0;
            hold      <= '0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            divByZero <= 1'b1;
                        end else begin
                            shift     <= dividend;
                            hold      <= divisor;
                            part      <= '0;
                            count     <= '0;
                            divByZero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    part  <= part_step;
                    shift <= shift_step;
                    count <= count + 1'b1;
                    // Outputs only change on the final step, never mid-run.
                    if (count == LAST) begin
                        quotient  <= shift_step;
                        remainder <= part_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and sweep bench for seq_divider

module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       divByZero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle. Latency is the number of
    // edges between the accepting edge and the edge after which done is seen.
    task automatic run_op(input string tag, input int a, input int b,
                          input int exp_lat, input int exp_busy,
                          input int exp_q, input int exp_r, input int exp_dbz);
        int lat;
        int busy_cnt;
        dividend = 8'(a);
        divisor  = 8'(b);
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_quotient"}, int'(quotient), exp_q);
        check({tag, "_remainder"}, int'(remainder), exp_r);
        check({tag, "_divbyzero"}, int'(divByZero), exp_dbz);
        @(negedge clk);
        check({tag, "_done_single"}, int'(done), 0);
        check({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int a;
        int b;
        int gap;
        int lat;
        int done_cnt;
        int q;
        int r;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_divbyzero", int'(divByZero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operation: 200 / 7 = 28 r 4, done 8 edges after accept, busy 9 cycles
        run_op("div200_7", 200, 7, 8, 9, 28, 4, 0);

        // Boundaries: divisor 1, dividend smaller than divisor
        run_op("div255_1", 255, 1, 8, 9, 255, 0, 0);
        run_op("div5_9", 5, 9, 8, 9, 0, 5, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("hold_quotient", int'(quotient), 0);
        check("hold_remainder", int'(remainder), 5);

        // Divide by zero goes straight to DONE; next valid op clears the flag
        run_op("div77_0", 77, 0, 0, 1, 255, 77, 1);
        run_op("div100_10", 100, 10, 8, 9, 10, 0, 0);

        // start during RUN is ignored
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        lat      = -1;
        done_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 2) begin
                dividend = 8'd9;
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    q   = int'(quotient);
                    r   = int'(remainder);
                end
            end
        end
        check("ignore_latency", lat, 8);
        check("ignore_done_count", done_cnt, 1);
        check("ignore_quotient", q, 28);
        check("ignore_remainder", r, 4);

        // Reset mid-RUN clears outputs asynchronously, no done follows
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_quotient", int'(quotient), 0);
        check("abort_remainder", int'(remainder), 0);
        check("abort_divbyzero", int'(divByZero), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        if (done) done_cnt++;
        @(negedge clk);
        if (done) done_cnt++;
        check("abort_no_done", done_cnt, 0);
        run_op("div50_6", 50, 6, 8, 9, 8, 2, 0);

        // Sweep with start held high: one completion every 10 cycles
        a        = int'($urandom_range(0, 255));
        b        = int'($urandom_range(1, 255));
        dividend = 8'(a);
        divisor  = 8'(b);
        start    = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done && gap < 30);
            check("sweep_done_seen", int'(done), 1);
            if (!done) break;
            if (i > 0) check("sweep_spacing", gap, 10);
            q = int'(quotient);
            r = int'(remainder);
            check("sweep_identity", int'((q * b + r == a) && (r < b)), 1);
            check("sweep_quotient", q, a / b);
            a        = int'($urandom_range(0, 255));
            b        = int'($urandom_range(1, 255));
            dividend = 8'(a);
            divisor  = 8'(b);
            if (i == 1999) start = 1'b0;
        end
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
